deser_queue_p: RTL and testbench

- Single-clock, parametrised successor to the serial-in deserializer plus its 8-entry queue.
- Assembles WIDTH-bit words from a bit-serial input qualified by write_in, and pushes each completed word into an internal DEPTH-entry FIFO.
- Exposes the FIFO head, occupancy and flags to the consumer. When the FIFO is full it applies backpressure through status_out and records dropped bits in a sticky overrun flag.

---
 rtl/deser_queue_p.sv | 100 ++++++++++
 tb/tb_deser_queue_p.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_queue_p.sv
// Serial-in deserializer feeding a DEPTH-entry circular FIFO.
// A completed word is held (status_out=0) until the FIFO can accept it.
module deser_queue_p #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int LEN_W     = $clog2(DEPTH + 1)
) (
    input  logic             clock1M,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             clear_in,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] len_out,
    output logic             status_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             overrun_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {COLLECT, PUSH} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic               last_bit, do_push, do_pop;

    assign full_out  = (len_out == LEN_W'(DEPTH));
    assign empty_out = (len_out == '0);
    assign data_out  = empty_out ? '0 : mem[rd_ptr];

    always_comb begin
        shift_next = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], data_in}
                                      : {data_in, shift_reg[WIDTH-1:1]};
        last_bit   = (bit_cnt == CNT_W'(WIDTH - 1));
        // A full FIFO still takes the held word when the head leaves this cycle.
        do_push    = (state == PUSH) && (!full_out || dequeue_in);
        do_pop     = dequeue_in && !empty_out;
        status_out = (state == COLLECT);
        state_next = state;
        case (state)
            COLLECT: if (write_in && !clear_in && last_bit) state_next = PUSH;
            PUSH:    if (do_push) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock1M) begin
        if (!reset) state <= COLLECT;
        else        state <= state_next;
    end

    // The shift register doubles as the held word while in PUSH.
    always_ff @(posedge clock1M) begin
        if (!reset) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            overrun_out <= 1'b0;
        end else if (clear_in) begin
            bit_cnt     <= '0;
            overrun_out <= 1'b0;
            if (state == COLLECT) shift_reg <= '0;
        end else if (write_in) begin
            if (state == COLLECT) begin
                shift_reg <= shift_next;
                bit_cnt   <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end else begin
                overrun_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock1M) begin
        if (reset && do_push) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            len_out <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   len_out <= len_out + LEN_W'(1);
                2'b01:   len_out <= len_out - LEN_W'(1);
                default: len_out <= len_out;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_queue_p.sv
// Bench for deser_queue_p: two instances (MSB-first and LSB-first) driven in parallel,
// checked against a queue-based reference model, vector tables and directed sequences.
module tb_deser_queue_p;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic clock1M = 1'b0;
    logic reset, data_in, write_in, clear_in, dequeue_in;

    logic [WIDTH-1:0] dm_data, dl_data;
    logic [LEN_W-1:0] dm_len, dl_len;
    logic dm_status, dm_full, dm_empty, dm_ovr;
    logic dl_status, dl_full, dl_empty, dl_ovr;

    always #5 clock1M = ~clock1M;

    deser_queue_p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_m (
        .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
        .clear_in(clear_in), .dequeue_in(dequeue_in), .data_out(dm_data),
        .len_out(dm_len), .status_out(dm_status), .full_out(dm_full),
        .empty_out(dm_empty), .overrun_out(dm_ovr));

    deser_queue_p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
        .clock1M(clock1M), .reset(reset), .data_in(data_in), .write_in(write_in),
        .clear_in(clear_in), .dequeue_in(dequeue_in), .data_out(dl_data),
        .len_out(dl_len), .status_out(dl_status), .full_out(dl_full),
        .empty_out(dl_empty), .overrun_out(dl_ovr));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: words as queues, the partial word as a bit count plus accumulators.
    logic [WIDTH-1:0] qm[$], ql[$];
    logic [WIDTH-1:0] acc_m, acc_l, held_m, held_l;
    bit held;
    bit ovr;
    int nbits;

    typedef struct {
        logic       d;
        logic       wr;
        logic       deq;
        int         len;
        logic       st;
        logic [7:0] dm;
        logic [7:0] dl;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit d, input bit w, input bit c, input bit q);
        bit pop, push;
        if (!r) begin
            qm.delete(); ql.delete();
            held = 0; ovr = 0; nbits = 0; acc_m = '0; acc_l = '0;
        end else begin
            pop  = q && (qm.size() > 0);
            push = held && ((qm.size() < DEPTH) || q);
            if (pop) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (push) begin
                qm.push_back(held_m);
                ql.push_back(held_l);
            end
            if (held) begin
                if (c) ovr = 0;
                else if (w) ovr = 1;
                if (push) held = 0;
            end else if (c) begin
                nbits = 0; ovr = 0; acc_m = '0; acc_l = '0;
            end else if (w) begin
                acc_m = {acc_m[WIDTH-2:0], d};
                acc_l[nbits] = d;
                nbits++;
                if (nbits == WIDTH) begin
                    held = 1; held_m = acc_m; held_l = acc_l; nbits = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        int n = qm.size();
        chk("len_m", int'(dm_len), n);
        chk("len_l", int'(dl_len), n);
        chk("data_m", int'(dm_data), n > 0 ? int'(qm[0]) : 0);
        chk("data_l", int'(dl_data), n > 0 ? int'(ql[0]) : 0);
        chk("status", int'({dm_status, dl_status}), held ? 0 : 3);
        chk("full", int'({dm_full, dl_full}), n == DEPTH ? 3 : 0);
        chk("empty", int'({dm_empty, dl_empty}), n == 0 ? 3 : 0);
        chk("overrun", int'({dm_ovr, dl_ovr}), ovr ? 3 : 0);
    endtask

    task automatic tick(input bit r, input bit d, input bit w, input bit c, input bit q);
        reset = r; data_in = d; write_in = w; clear_in = c; dequeue_in = q;
        @(posedge clock1M);
        model_step(r, d, w, c, q);
        #1;
        model_check();
    endtask

    task automatic send_word(input logic [7:0] wd, input bit deq);
        for (int i = WIDTH - 1; i >= 0; i--) tick(1, wd[i], 1, 0, deq);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_len"}, int'(dm_len), 0);
        chk({tag, "_data"}, int'(dm_data), 0);
        chk({tag, "_status"}, int'(dm_status), 1);
        chk({tag, "_flags"}, int'({dm_full, dm_empty, dm_ovr}), 3'b010);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && !dm_empty; k++) tick(1, 0, 0, 0, 1);
        chk("drain_empty", int'(dm_empty), 1);
    endtask

    initial begin
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check_reset_outputs("reset");

        // Bit order: A5 (palindrome), then 1,1,0,0,0,0,0,0 -> C0 / 03.
        tbl[0]  = '{1, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[1]  = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[2]  = '{1, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[3]  = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[4]  = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[5]  = '{1, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[6]  = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[7]  = '{1, 1, 0, 0, 0, 8'h00, 8'h00};
        tbl[8]  = '{0, 0, 0, 1, 1, 8'hA5, 8'hA5};
        tbl[9]  = '{0, 0, 1, 0, 1, 8'h00, 8'h00};
        tbl[10] = '{1, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[11] = '{1, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[12] = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[13] = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[14] = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[15] = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[16] = '{0, 1, 0, 0, 1, 8'h00, 8'h00};
        tbl[17] = '{0, 1, 0, 0, 0, 8'h00, 8'h00};
        tbl[18] = '{0, 0, 0, 1, 1, 8'hC0, 8'h03};
        tbl[19] = '{0, 0, 1, 0, 1, 8'h00, 8'h00};
        for (int i = 0; i < 20; i++) begin
            tick(1, tbl[i].d, tbl[i].wr, 0, tbl[i].deq);
            chk($sformatf("tbl%0d_len", i), int'(dm_len), tbl[i].len);
            chk($sformatf("tbl%0d_status", i), int'(dm_status), int'(tbl[i].st));
            chk($sformatf("tbl%0d_dm", i), int'(dm_data), int'(tbl[i].dm));
            chk($sformatf("tbl%0d_dl", i), int'(dl_data), int'(tbl[i].dl));
        end

        // Fill to full, hold a 9th word under backpressure, overrun, then pop to admit it.
        for (int i = 1; i <= DEPTH; i++) begin
            send_word(8'(i), 0);
            tick(1, 0, 0, 0, 0);
        end
        chk("fill_full", int'({dm_full, dm_len}), {1'b1, LEN_W'(DEPTH)});
        send_word(8'h09, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("bp_status", int'(dm_status), 0);
        tick(1, 1, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        chk("bp_overrun", int'(dm_ovr), 1);
        tick(1, 0, 0, 0, 1);
        chk("bp_pop_len", int'(dm_len), DEPTH);
        chk("bp_pop_head", int'(dm_data), 8'h02);
        chk("bp_pop_status", int'(dm_status), 1);
        tick(1, 0, 0, 1, 0);
        chk("clear_ovr", int'(dm_ovr), 0);
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("order_%0d", k), int'(dm_data), k);
            tick(1, 0, 0, 0, 1);
        end
        chk("drained_empty", int'(dm_empty), 1);
        tick(1, 0, 0, 0, 1);
        chk("pop_empty_len", int'(dm_len), 0);

        // Overrun in PUSH sets the flag; coinciding clear wins.
        send_word(8'h11, 0);
        tick(1, 1, 1, 0, 0);
        chk("push_overrun", int'(dm_ovr), 1);
        send_word(8'h22, 0);
        tick(1, 1, 1, 1, 0);
        chk("clear_beats_overrun", int'(dm_ovr), 0);
        chk("clear_keeps_push", int'(dm_len), 2);
        drain();

        // 20 words with interleaved pops, across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            send_word(8'(i * 13 + 5), (i % 2) == 1);
            tick(1, 0, 0, 0, (i % 3) == 0);
        end
        drain();
        tick(1, 0, 0, 0, 1);
        chk("extra_pop_len", int'(dm_len), 0);

        // Partial word discarded by clear.
        for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, 0);
        tick(1, 0, 0, 1, 0);
        send_word(8'h3C, 0);
        tick(1, 0, 0, 0, 0);
        chk("clr_partial_len", int'(dm_len), 1);
        chk("clr_partial_data", int'(dm_data), 8'h3C);
        chk("clr_partial_ovr", int'(dm_ovr), 0);

        // Reset mid-word, then reset while holding a word over a full FIFO.
        for (int i = 0; i < 4; i++) tick(1, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 1);
        check_reset_outputs("rst_mid");
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_word(8'(i + 8'h40), 0);
            tick(1, 0, 0, 0, 0);
        end
        tick(1, 1, 1, 0, 0);
        chk("pre_rst_full", int'({dm_full, dm_status, dm_ovr}), 3'b101);
        tick(0, 1, 1, 0, 1);
        check_reset_outputs("rst_push");
        send_word(8'h5A, 0);
        tick(1, 0, 0, 0, 0);
        chk("post_rst_len", int'(dm_len), 1);
        chk("post_rst_data", int'(dm_data), 8'h5A);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++)
            tick($urandom_range(0, 299) != 0, 1'($urandom), ($urandom % 4) != 0,
                 $urandom_range(0, 59) == 0, ($urandom % 3) == 0);
        tick(1, 0, 0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
